retire_commit: RTL and testbench
================================

# retire_commit

Consumer end of the retire bus, driven by the reorder buffer. Each cycle it takes the ROB head entry and commits it: it writes the architectural register file and clears the matching register-status-table entry. Committed store tags go into a small queue that drains to the load/store unit over a valid/ack handshake. A taken branch produces a registered front-end redirect, and the block keeps a 64-bit retired-instruction counter.

## Interface
- `STQ_DEPTH`, 4: committed-store queue depth; power of two, at least 2.
- `TAG_W`, 6: ROB tag width.
- `i_clk`  in  1  clock.
- `i_rst_n`  in  1  reset. One clock; reset is asynchronous and active-low.
- `rb_valid`, `rb_spec_valid`  in  1  ROB head is occupied; ROB head result is ready.
- `rb_rd_tag`  in  TAG_W  tag of the retiring entry.
- `rb_rd_reg`  in  5  destination register.
- `rb_data`  in  32  result; for a branch, the resolved target.
- `rb_pc`  in  32  PC of the retiring instruction.
- `rb_instr_type`  in  `dispatch_type`  instruction class.
- `rb_branch_taken`, `rb_flush`  in  1  branch outcome; flush request.
- `o_retire_stall`  out  1  store queue full, so a store must not be presented.
- `o_arf_wen`  out  1  architectural register file write enable.
- `o_arf_waddr`  out  5  write address.
- `o_arf_wdata`  out  32  write data.
- `o_rst_clr_en`  out  1  clear the register-status-table entry.
- `o_rst_clr_reg`  out  5  register to clear.
- `o_rst_clr_tag`  out  TAG_W  tag that must still match for the clear to take effect.
- `o_st_commit_valid`  out  1  a committed store is offered to the LSU.
- `o_st_commit_tag`  out  TAG_W  tag of that store.
- `i_st_commit_ack`  in  1  LSU has accepted the store.
- `o_redirect_valid`  out  1  one-cycle front-end redirect pulse.
- `o_redirect_pc`  out  32  redirect target.
- `o_instret`  out  64  retired-instruction count.
- `o_stq_overflow`  out  1  sticky error flag.

## Operation
- Retire event: `ret = rb_valid & rb_spec_valid`. With `ret` low, nothing changes.
- Register writers are INT, MULT, DIV and LOAD. On `ret` with `rb_rd_reg != 0`, register the ARF write and the RST clear using `rb_rd_reg`, `rb_data` and `rb_rd_tag`.
- `rb_rd_reg == 0` produces no write and no clear.
- STORE on `ret`: push `rb_rd_tag` into the store queue. There is no ARF write.
- Store queue rules:
  - The head is shown on `o_st_commit_*`; `o_st_commit_valid` is high when the queue is not empty.
  - Pop on `o_st_commit_valid & i_st_commit_ack`.
  - `o_retire_stall = (count == STQ_DEPTH)`, driven combinationally.
  - Push and pop in the same cycle: count is unchanged. When the queue is full, this pop frees the slot for that push.
  - A push while full with no pop is dropped and sets `o_stq_overflow` until reset.
- BRANCH on `ret` makes no ARF write. If `rb_flush` is high, register `o_redirect_valid = 1` and `o_redirect_pc = rb_data`.
- A not-taken branch only retires.
- Flush does not empty the store queue; its contents are already architecturally committed.
- `o_instret` increments by 1 on every `ret` of any class, wrapping modulo 2^64.
- An unknown `rb_instr_type` counts as retired and has no other effect.

## Timing
- ARF write, RST clear and redirect outputs are registered: asserted exactly one cycle after `ret`, for one cycle. Back-to-back retires give back-to-back pulses.
- `o_instret` is updated on the clock edge that samples `ret`.
- The store queue is a FIFO with registered pointers. A tag pushed at edge N can be offered from cycle N+1. It is removed on the edge where the ack is sampled, and the next entry appears in the following cycle.
- `o_st_commit_valid`/`o_st_commit_tag` hold stable until ack. Ack while the queue is empty is ignored.
- Reset, at any time and asynchronously, clears every output to 0. This includes the queue pointers and count, so `o_retire_stall = 0`.

## Structure
- `dispatch_type`, `TAG_W` and the x0 index constant belong in the shared utils package.
- One sub-module, `commit_stq_fifo`: parameterised tag FIFO with full/empty/count, plus wrap-around pointers carrying one extra bit.
- The top level holds the decode, the output registers and the counter.

## Test plan
- INT retire, `rd_reg = 5`, `data = 0xDEADBEEF`, `tag = 3` -> next cycle `o_arf_wen = 1`, `waddr = 5`, `wdata = 0xDEADBEEF`, `clr_tag = 3`; `o_instret = 1`.
- LOAD retire with `rd_reg = 0` -> no `o_arf_wen`, no `o_rst_clr_en`; `o_instret` still increments.
- Five STORE retires with tags 1–5, ack held low, `STQ_DEPTH = 4` -> stall after the fourth; the fifth sets `o_stq_overflow`; the queue drains tags 1, 2, 3, 4 in order after ack.
- Queue full, then push and ack in the same cycle -> count stays 4, no overflow, and the head advances.
- Taken BRANCH with `rb_flush = 1`, `data = 0x0000_0200` -> one cycle later `o_redirect_valid = 1` for one cycle with `o_redirect_pc = 0x200`; a non-empty store queue is untouched.
- `i_rst_n` low mid-drain with the queue holding 3 entries -> all outputs 0 at once; after release the queue is empty and `o_instret = 0`.

Source files
------------

// File: rtl/retire_commit_pkg.sv
// Shared retire-side types: dispatch classes, ROB tag width and the x0 index.
package retire_commit_pkg;

  localparam int TAG_W = 6;
  localparam logic [4:0] X0_REG = 5'd0;

  typedef enum logic [2:0] {
    DT_INT    = 3'd0,
    DT_MULT   = 3'd1,
    DT_DIV    = 3'd2,
    DT_LOAD   = 3'd3,
    DT_STORE  = 3'd4,
    DT_BRANCH = 3'd5
  } dispatch_type;

  function automatic logic writes_reg(input dispatch_type t);
    return (t == DT_INT) || (t == DT_MULT) || (t == DT_DIV) || (t == DT_LOAD);
  endfunction

endpackage

// File: rtl/commit_stq_fifo.sv
// Committed-store tag FIFO; pointers carry one extra wrap bit for full/empty.
module commit_stq_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 6
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic [W-1:0]           data_i,
  input  logic                   pop_i,
  output logic [W-1:0]           head_o,
  output logic                   empty_o,
  output logic                   full_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   push_drop_o
);
  import retire_commit_pkg::*;

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
  logic [W-1:0] mem_q [DEPTH];
  logic         do_push, do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign count_o = wr_q - rd_q;

  // A pop in the same cycle frees the slot, so a push into a full queue is kept.
  assign do_pop      = pop_i & ~empty_o;
  assign do_push     = push_i & (~full_o | do_pop);
  assign push_drop_o = push_i & full_o & ~do_pop;

  assign head_o = empty_o ? '0 : mem_q[rd_q[AW-1:0]];
  assign wr_d   = wr_q + {{AW{1'b0}}, do_push};
  assign rd_d   = rd_q + {{AW{1'b0}}, do_pop};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/retire_commit.sv
// Retire-bus consumer: commits the ROB head to ARF/RST, queues stores for the
// LSU, raises front-end redirects and counts retired instructions.
module retire_commit #(
  parameter int STQ_DEPTH = 4,
  parameter int TAG_W     = retire_commit_pkg::TAG_W
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            rb_valid,
  input  logic                            rb_spec_valid,
  input  logic [TAG_W-1:0]                rb_rd_tag,
  input  logic [4:0]                      rb_rd_reg,
  input  logic [31:0]                     rb_data,
  input  logic [31:0]                     rb_pc,
  input  retire_commit_pkg::dispatch_type rb_instr_type,
  input  logic                            rb_branch_taken,
  input  logic                            rb_flush,
  output logic                            o_retire_stall,
  output logic                            o_arf_wen,
  output logic [4:0]                      o_arf_waddr,
  output logic [31:0]                     o_arf_wdata,
  output logic                            o_rst_clr_en,
  output logic [4:0]                      o_rst_clr_reg,
  output logic [TAG_W-1:0]                o_rst_clr_tag,
  output logic                            o_st_commit_valid,
  output logic [TAG_W-1:0]                o_st_commit_tag,
  input  logic                            i_st_commit_ack,
  output logic                            o_redirect_valid,
  output logic [31:0]                     o_redirect_pc,
  output logic [63:0]                     o_instret,
  output logic                            o_stq_overflow
);
  import retire_commit_pkg::*;

  logic                     ret, wen_d, redir_d, st_push, stq_empty, stq_full, stq_drop;
  logic [$clog2(STQ_DEPTH):0] stq_count;
  logic                     wen_q, redir_q, ovf_q;
  logic [4:0]               waddr_q;
  logic [31:0]              wdata_q, rpc_q;
  logic [TAG_W-1:0]         tag_q;
  logic [63:0]              instret_q, instret_d;
  logic                     unused_ok;

  assign ret       = rb_valid & rb_spec_valid;
  assign wen_d     = ret && writes_reg(rb_instr_type) && (rb_rd_reg != X0_REG);
  assign redir_d   = ret && (rb_instr_type == DT_BRANCH) && rb_flush;
  assign st_push   = ret && (rb_instr_type == DT_STORE);
  assign instret_d = instret_q + {63'b0, ret};

  // Branch direction and PC are carried on the bus but not needed for commit.
  assign unused_ok = ^{rb_branch_taken, rb_pc, stq_count};

  commit_stq_fifo #(
    .DEPTH (STQ_DEPTH),
    .W     (TAG_W)
  ) u_stq (
    .clk_i       (i_clk),
    .rst_ni      (i_rst_n),
    .push_i      (st_push),
    .data_i      (rb_rd_tag),
    .pop_i       (i_st_commit_ack),
    .head_o      (o_st_commit_tag),
    .empty_o     (stq_empty),
    .full_o      (stq_full),
    .count_o     (stq_count),
    .push_drop_o (stq_drop)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wen_q     <= 1'b0;
      redir_q   <= 1'b0;
      ovf_q     <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      tag_q     <= '0;
      rpc_q     <= '0;
      instret_q <= '0;
    end else begin
      wen_q     <= wen_d;
      redir_q   <= redir_d;
      instret_q <= instret_d;
      if (wen_d) begin
        waddr_q <= rb_rd_reg;
        wdata_q <= rb_data;
        tag_q   <= rb_rd_tag;
      end
      if (redir_d)  rpc_q <= rb_data;
      if (stq_drop) ovf_q <= 1'b1;
    end
  end

  assign o_retire_stall    = stq_full;
  assign o_st_commit_valid = ~stq_empty;
  assign o_arf_wen         = wen_q;
  assign o_arf_waddr       = waddr_q;
  assign o_arf_wdata       = wdata_q;
  assign o_rst_clr_en      = wen_q;
  assign o_rst_clr_reg     = waddr_q;
  assign o_rst_clr_tag     = tag_q;
  assign o_redirect_valid  = redir_q;
  assign o_redirect_pc     = rpc_q;
  assign o_instret         = instret_q;
  assign o_stq_overflow    = ovf_q;

endmodule

// File: tb/tb_retire_commit.sv
// Directed bench for retire_commit: vector table for single retires plus
// hand-written store-queue, redirect and reset sequences.
module tb_retire_commit;
  import retire_commit_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         rb_valid = 1'b0, rb_spec_valid = 1'b0;
  logic [5:0]   rb_rd_tag = '0;
  logic [4:0]   rb_rd_reg = '0;
  logic [31:0]  rb_data = '0, rb_pc = '0;
  dispatch_type rb_instr_type = DT_INT;
  logic         rb_branch_taken = 1'b0, rb_flush = 1'b0;
  logic         ack = 1'b0;
  logic         stall, wen, clr_en, st_valid, redir, ovf;
  logic [4:0]   waddr, clr_reg;
  logic [31:0]  wdata, rpc;
  logic [5:0]   clr_tag, st_tag;
  logic [63:0]  instret;

  int tests = 0;
  int fails = 0;
  longint unsigned exp_instret = 0;

  always #5 clk = ~clk;

  retire_commit #(.STQ_DEPTH(4), .TAG_W(6)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .rb_valid(rb_valid), .rb_spec_valid(rb_spec_valid),
    .rb_rd_tag(rb_rd_tag), .rb_rd_reg(rb_rd_reg), .rb_data(rb_data), .rb_pc(rb_pc),
    .rb_instr_type(rb_instr_type), .rb_branch_taken(rb_branch_taken), .rb_flush(rb_flush),
    .o_retire_stall(stall), .o_arf_wen(wen), .o_arf_waddr(waddr), .o_arf_wdata(wdata),
    .o_rst_clr_en(clr_en), .o_rst_clr_reg(clr_reg), .o_rst_clr_tag(clr_tag),
    .o_st_commit_valid(st_valid), .o_st_commit_tag(st_tag), .i_st_commit_ack(ack),
    .o_redirect_valid(redir), .o_redirect_pc(rpc), .o_instret(instret),
    .o_stq_overflow(ovf)
  );

  typedef struct {
    logic        v, sv;
    logic [2:0]  ty;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [5:0]  tag;
    logic        flush;
    logic        ewen, eredir, einc;
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic sv, input logic [2:0] ty, input logic [4:0] rd,
                       input logic [31:0] data, input logic [5:0] tag, input logic flush);
    rb_valid = v; rb_spec_valid = sv; rb_instr_type = dispatch_type'(ty);
    rb_rd_reg = rd; rb_data = data; rb_rd_tag = tag; rb_flush = flush;
    rb_branch_taken = flush; rb_pc = 32'h1000;
    if (v && sv) exp_instret++;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 3'd0, 5'd0, 32'd0, 6'd0, 1'b0);
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, " stall"}, 64'(stall), 64'd0);
    chk({pfx, " wen"}, 64'(wen), 64'd0);
    chk({pfx, " clr_en"}, 64'(clr_en), 64'd0);
    chk({pfx, " waddr"}, 64'(waddr), 64'd0);
    chk({pfx, " wdata"}, 64'(wdata), 64'd0);
    chk({pfx, " clr_tag"}, 64'(clr_tag), 64'd0);
    chk({pfx, " st_valid"}, 64'(st_valid), 64'd0);
    chk({pfx, " st_tag"}, 64'(st_tag), 64'd0);
    chk({pfx, " redir"}, 64'(redir), 64'd0);
    chk({pfx, " rpc"}, 64'(rpc), 64'd0);
    chk({pfx, " instret"}, instret, 64'd0);
    chk({pfx, " ovf"}, 64'(ovf), 64'd0);
  endtask

  task automatic push_store(input logic [5:0] tag);
    @(negedge clk);
    drive(1'b1, 1'b1, 3'd4, 5'd0, 32'd0, tag, 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle(); ack = 1'b0;
    rst_n = 1'b0; #2;
    rst_n = 1'b1;
    exp_instret = 0;
  endtask

  initial begin
    //          v     sv    ty    rd     data           tag    fl    wen   rdir  inc
    vt[0] = '{1'b1, 1'b1, 3'd0, 5'd5,  32'hDEADBEEF, 6'd3,  1'b0, 1'b1, 1'b0, 1'b1};
    vt[1] = '{1'b1, 1'b1, 3'd3, 5'd0,  32'h11111111, 6'd4,  1'b0, 1'b0, 1'b0, 1'b1};
    vt[2] = '{1'b1, 1'b0, 3'd1, 5'd7,  32'h22222222, 6'd5,  1'b0, 1'b0, 1'b0, 1'b0};
    vt[3] = '{1'b1, 1'b1, 3'd2, 5'd31, 32'h12345678, 6'd63, 1'b0, 1'b1, 1'b0, 1'b1};
    vt[4] = '{1'b1, 1'b1, 3'd5, 5'd0,  32'h00000200, 6'd6,  1'b1, 1'b0, 1'b1, 1'b1};
    vt[5] = '{1'b1, 1'b1, 3'd5, 5'd0,  32'h00000300, 6'd7,  1'b0, 1'b0, 1'b0, 1'b1};
    vt[6] = '{1'b1, 1'b1, 3'd7, 5'd9,  32'h33333333, 6'd8,  1'b0, 1'b0, 1'b0, 1'b1};
    vt[7] = '{1'b1, 1'b1, 3'd1, 5'd1,  32'h00000001, 6'd0,  1'b0, 1'b1, 1'b0, 1'b1};

    // reset state
    #12;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // single-retire vectors, applied back to back
    foreach (vt[i]) begin
      @(negedge clk);
      drive(vt[i].v, vt[i].sv, vt[i].ty, vt[i].rd, vt[i].data, vt[i].tag, vt[i].flush);
      @(posedge clk); #1;
      chk($sformatf("v%0d wen", i), 64'(wen), 64'(vt[i].ewen));
      chk($sformatf("v%0d clr_en", i), 64'(clr_en), 64'(vt[i].ewen));
      if (vt[i].ewen) begin
        chk($sformatf("v%0d waddr", i), 64'(waddr), 64'(vt[i].rd));
        chk($sformatf("v%0d wdata", i), 64'(wdata), 64'(vt[i].data));
        chk($sformatf("v%0d clr_reg", i), 64'(clr_reg), 64'(vt[i].rd));
        chk($sformatf("v%0d clr_tag", i), 64'(clr_tag), 64'(vt[i].tag));
      end
      chk($sformatf("v%0d redir", i), 64'(redir), 64'(vt[i].eredir));
      if (vt[i].eredir) chk($sformatf("v%0d rpc", i), 64'(rpc), 64'(vt[i].data));
      chk($sformatf("v%0d instret", i), instret, exp_instret);
    end
    @(negedge clk); idle();
    @(posedge clk); #1;
    chk("idle wen", 64'(wen), 64'd0);
    chk("idle instret", instret, 64'd7);

    // five stores with no ack: full after four, fifth overflows
    for (int k = 1; k <= 5; k++) begin
      push_store(6'(k));
      chk($sformatf("stq%0d stall", k), 64'(stall), 64'(k >= 4));
      chk($sformatf("stq%0d wen", k), 64'(wen), 64'd0);
    end
    chk("stq ovf", 64'(ovf), 64'd1);
    chk("stq instret", instret, exp_instret);
    for (int e = 1; e <= 4; e++) begin
      @(negedge clk); idle(); ack = 1'b1;
      chk($sformatf("drain%0d valid", e), 64'(st_valid), 64'd1);
      chk($sformatf("drain%0d tag", e), 64'(st_tag), 64'(e));
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("drained valid", 64'(st_valid), 64'd0);
    chk("drained stall", 64'(stall), 64'd0);
    chk("ovf sticky", 64'(ovf), 64'd1);
    @(posedge clk); #1;
    chk("ack on empty", 64'(st_valid), 64'd0);

    // full queue, push and ack in the same cycle
    do_reset();
    ack = 1'b0;
    for (int k = 10; k <= 13; k++) push_store(6'(k));
    chk("full stall", 64'(stall), 64'd1);
    @(negedge clk);
    drive(1'b1, 1'b1, 3'd4, 5'd0, 32'd0, 6'd14, 1'b0);
    ack = 1'b1;
    chk("pp head before", 64'(st_tag), 64'd10);
    @(posedge clk); #1;
    chk("pp stall", 64'(stall), 64'd1);
    chk("pp ovf", 64'(ovf), 64'd0);
    chk("pp head after", 64'(st_tag), 64'd11);
    for (int e = 11; e <= 14; e++) begin
      @(negedge clk); idle(); ack = 1'b1;
      chk($sformatf("pp drain%0d", e), 64'(st_tag), 64'(e));
      @(posedge clk); #1;
    end
    chk("pp empty", 64'(st_valid), 64'd0);
    chk("pp instret", instret, 64'd5);

    // taken branch with flush while a store is queued
    @(negedge clk); ack = 1'b0;
    drive(1'b1, 1'b1, 3'd4, 5'd0, 32'd0, 6'd20, 1'b0);
    @(negedge clk);
    drive(1'b1, 1'b1, 3'd5, 5'd0, 32'h00000200, 6'd21, 1'b1);
    @(posedge clk); #1;
    chk("br redir", 64'(redir), 64'd1);
    chk("br rpc", 64'(rpc), 64'h200);
    chk("br wen", 64'(wen), 64'd0);
    chk("br stq valid", 64'(st_valid), 64'd1);
    chk("br stq tag", 64'(st_tag), 64'd20);
    @(negedge clk); idle();
    @(posedge clk); #1;
    chk("br pulse end", 64'(redir), 64'd0);
    chk("br stq kept", 64'(st_tag), 64'd20);
    chk("br instret", instret, exp_instret);

    // asynchronous reset mid-drain with three entries queued
    for (int k = 21; k <= 23; k++) push_store(6'(k));
    @(negedge clk); idle(); ack = 1'b1;
    @(posedge clk); #1;
    chk("pre-rst head", 64'(st_tag), 64'd21);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async rst");
    @(negedge clk);
    ack = 1'b0;
    rst_n = 1'b1;
    exp_instret = 0;
    @(posedge clk); #1;
    chk("post-rst valid", 64'(st_valid), 64'd0);
    chk("post-rst stall", 64'(stall), 64'd0);
    chk("post-rst instret", instret, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
